distortion_sample_sequencer: RTL and testbench

- Sequences the distortion datapath for one stereo sample pair per audio-sample strobe.
- Time-shares a single signed multiplier and a single clip/saturate unit between the left and right channels.
- Sits between the codec sample interface and the output mixer.
- Consumes gain, threshold and mode from the distortion parameter controller.

---
 rtl/distortion_sample_sequencer.sv | 147 ++++++++++++++
 tb/tb_distortion_sample_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/distortion_sample_sequencer.sv
// Stereo distortion sequencer: one shared multiplier and one clip/saturate
// unit, used by left then right, publishing a pair 5 cycles after acceptance.
module distortion_sample_sequencer #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int THR_W  = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] in_left,
    input  logic signed [DATA_W-1:0] in_right,
    input  logic signed [GAIN_W-1:0] gain,
    input  logic signed [THR_W-1:0]  threshold,
    input  logic        [1:0]        mode,
    input  logic                     overrun_clr,
    output logic signed [DATA_W-1:0] out_left,
    output logic signed [DATA_W-1:0] out_right,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int CMP_W  = ((PROD_W > THR_W) ? PROD_W : THR_W) + 1;

    localparam logic signed [DATA_W-1:0] SAT_MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN_D = ~SAT_MAX_D;
    localparam logic signed [CMP_W-1:0]  SAT_MAX   = CMP_W'(SAT_MAX_D);
    localparam logic signed [CMP_W-1:0]  SAT_MIN   = CMP_W'(SAT_MIN_D);

    typedef enum logic [2:0] {
        IDLE,
        MUL_L,
        CLIP_L,
        MUL_R,
        CLIP_R,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   left_q, right_q;
    logic signed [GAIN_W-1:0]   gain_q;
    logic signed [THR_W-1:0]    thr_q;
    logic        [1:0]          mode_q;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic signed [PROD_W-1:0]   mul_a, mul_g;
    logic signed [CMP_W-1:0]    prod_x, thr_x, clip_x;
    logic signed [DATA_W-1:0]   res_d, res_l_q;
    logic signed [DATA_W-1:0]   out_left_q, out_right_q;
    logic                       out_valid_q;
    logic                       overrun_q, overrun_d;
    logic                       accept;

    assign accept = sample_valid && (state_q == IDLE || state_q == DONE);
    assign busy   = (state_q == MUL_L) || (state_q == CLIP_L) ||
                    (state_q == MUL_R) || (state_q == CLIP_R);

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_valid) state_d = MUL_L;
            MUL_L:   state_d = CLIP_L;
            CLIP_L:  state_d = MUL_R;
            MUL_R:   state_d = CLIP_R;
            CLIP_R:  state_d = DONE;
            DONE:    state_d = sample_valid ? MUL_L : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set beats clear so a drop in the clearing cycle is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (sample_valid && busy)
            overrun_d = 1'b1;
        else if (overrun_clr)
            overrun_d = 1'b0;
    end

    // Modes 1 and 3 apply gain; the others multiply by one.
    always_comb begin
        mul_a  = (state_q == MUL_R) ? PROD_W'(right_q) : PROD_W'(left_q);
        mul_g  = mode_q[0] ? PROD_W'(gain_q) : PROD_W'(1);
        prod_d = mul_a * mul_g;
    end

    always_comb begin
        prod_x = CMP_W'(prod_q);
        thr_x  = thr_q[THR_W-1] ? '0 : CMP_W'(thr_q);
        clip_x = prod_x;
        if (mode_q != 2'd0) begin
            if (prod_x > thr_x)
                clip_x = thr_x;
            else if (prod_x < -thr_x)
                clip_x = -thr_x;
        end
        if (clip_x > SAT_MAX)
            res_d = SAT_MAX_D;
        else if (clip_x < SAT_MIN)
            res_d = SAT_MIN_D;
        else
            res_d = clip_x[DATA_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            left_q      <= '0;
            right_q     <= '0;
            gain_q      <= '0;
            thr_q       <= '0;
            mode_q      <= '0;
            prod_q      <= '0;
            res_l_q     <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            overrun_q   <= overrun_d;
            out_valid_q <= (state_q == CLIP_R);
            if (accept) begin
                left_q  <= in_left;
                right_q <= in_right;
                gain_q  <= gain;
                thr_q   <= threshold;
                mode_q  <= mode;
            end
            if (state_q == MUL_L || state_q == MUL_R)
                prod_q <= prod_d;
            if (state_q == CLIP_L)
                res_l_q <= res_d;
            if (state_q == CLIP_R) begin
                out_left_q  <= res_l_q;
                out_right_q <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_distortion_sample_sequencer.sv
// Bench for distortion_sample_sequencer: directed vectors, timing/overrun,
// reset abort and random back-to-back traffic against a scoreboard.
module tb_distortion_sample_sequencer;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               sample_valid;
    logic signed [15:0] in_left, in_right;
    logic signed [15:0] gain;
    logic signed [31:0] threshold;
    logic        [1:0]  mode;
    logic               overrun_clr;
    logic signed [15:0] out_left, out_right;
    logic               out_valid, busy, overrun;

    distortion_sample_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .sample_valid(sample_valid),
        .in_left(in_left), .in_right(in_right), .gain(gain),
        .threshold(threshold), .mode(mode), .overrun_clr(overrun_clr),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid at cyc %0d: got (%0d,%0d), none expected",
                         cyc, out_left, out_right);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_left !== e.l || out_right !== e.r) begin
                    errors++;
                    $display("FAIL out_data: got (%0d,%0d) expected (%0d,%0d)",
                             out_left, out_right, e.l, e.r);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL out_latency: got cyc %0d expected cyc %0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic signed [15:0] model(input logic [1:0] m,
                                                 input logic signed [15:0] g,
                                                 input logic signed [31:0] t,
                                                 input logic signed [15:0] s);
        longint p, te;
        logic signed [15:0] res;
        p = (m == 2'd1 || m == 2'd3) ? longint'(s) * longint'(g) : longint'(s);
        if (m != 2'd0) begin
            te = (t < 0) ? 0 : longint'(t);
            if (p > te) p = te;
            if (p < -te) p = -te;
        end
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        res = p[15:0];
        return res;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic signed [15:0] g,
                         input logic signed [31:0] t, input logic signed [15:0] l,
                         input logic signed [15:0] r, input logic push,
                         input logic signed [15:0] el, input logic signed [15:0] er);
        exp_t e;
        sample_valid = 1'b1;
        mode = m; gain = g; threshold = t;
        in_left = l; in_right = r;
        if (push) begin
            e.l = el; e.r = er; e.cyc = cyc + 5;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        sample_valid = 0; overrun_clr = 0;
        in_left = 0; in_right = 0; gain = 0; threshold = 0; mode = 0;
        #12;
        checks++;
        if (out_left !== 16'sd0 || out_right !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got (%0d,%0d) expected (0,0)", out_left, out_right);
        end
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_overrun", overrun, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [1:0]         tm [5] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2};
        logic signed [15:0] tg [5] = '{16'sd4, 16'sd4, 16'sd50, 16'sd7, 16'sd3};
        logic signed [31:0] tt [5] = '{32'sd16000, 32'sd16000, 32'sd40000, 32'sd0, -32'sd5};
        logic signed [15:0] tl [5] = '{16'sd1000, -16'sd5000, 16'sd32767, -16'sd1234, 16'sd100};
        logic signed [15:0] tr [5] = '{16'sd5000, -16'sd3000, -16'sd32768, 16'sd32767, -16'sd100};
        logic signed [15:0] el [5] = '{16'sd4000, -16'sd16000, 16'sd32767, -16'sd1234, 16'sd0};
        logic signed [15:0] er [5] = '{16'sd16000, -16'sd12000, -16'sd32768, 16'sd32767, 16'sd0};
        for (int i = 0; i < 5; i++) begin
            drive(tm[i], tg[i], tt[i], tl[i], tr[i], 1'b1, el[i], er[i]);
            tick();
            sample_valid = 1'b0;
            check_bit("busy_in_flight", busy, 1'b1);
            wait_drain();
            tick();
            check_bit("busy_idle", busy, 1'b0);
            check_bit("out_valid_pulse", out_valid, 1'b0);
            checks++;
            if (out_left !== el[i] || out_right !== er[i]) begin
                errors++;
                $display("FAIL out_hold: got (%0d,%0d) expected (%0d,%0d)",
                         out_left, out_right, el[i], er[i]);
            end
        end
    endtask

    task automatic test_timing_overrun();
        drive(2'd1, 16'sd4, 32'sd16000, 16'sd1000, 16'sd5000, 1'b1, 16'sd4000, 16'sd16000);
        tick();
        sample_valid = 1'b0;
        tick();
        gain = 16'sd9;
        tick();
        drive(2'd1, 16'sd9, 32'sd16000, 16'sd7, 16'sd7, 1'b0, 16'sd0, 16'sd0);
        check_bit("busy_at_drop", busy, 1'b1);
        tick();
        sample_valid = 1'b0;
        check_bit("overrun_set", overrun, 1'b1);
        check_bit("busy_clip_r", busy, 1'b1);
        tick();
        check_bit("busy_done", busy, 1'b0);
        drive(2'd3, 16'sd9, 32'sd16000, -16'sd100, 16'sd200, 1'b1, -16'sd900, 16'sd1800);
        tick();
        sample_valid = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_bit("overrun_clr", overrun, 1'b0);
        tick();
        tick();
        tick();
        drive(2'd1, 16'sd2, 32'sd30000, 16'sd11, 16'sd22, 1'b0, 16'sd0, 16'sd0);
        tick();
        sample_valid = 1'b0;
        check_bit("busy_before_abort", busy, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pair_b_missing: %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if (out_left !== 16'sd0 || out_right !== 16'sd0) begin
            errors++;
            $display("FAIL abort_outputs: got (%0d,%0d) expected (0,0)", out_left, out_right);
        end
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_out_valid", out_valid, 1'b0);
        tick();
        tick();
        RST_N = 1'b1;
        repeat (8) tick();
        drive(2'd1, -16'sd2, 32'sd1000, 16'sd300, -16'sd700, 1'b1, -16'sd600, 16'sd1000);
        tick();
        sample_valid = 1'b0;
        wait_drain();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]         m;
        logic signed [15:0] g, l, r;
        logic signed [31:0] t;
        for (int i = 0; i < 16; i++) begin
            m = 2'($urandom_range(0, 3));
            g = 16'($urandom);
            t = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40000));
            l = 16'($urandom);
            r = 16'($urandom);
            drive(m, g, t, l, r, 1'b1, model(m, g, t, l), model(m, g, t, r));
            tick();
            sample_valid = 1'b0;
            repeat (4) tick();
        end
        wait_drain();
        tick();
        check_bit("b2b_no_overrun", overrun, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_modes();
        test_timing_overrun();
        test_back_to_back();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
